// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push/pop/flush and occupancy count
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  T                     push_data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output T                     head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  // Flush overrides both push and pop in the same cycle.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assert property (@(posedge clk) disable iff (reset)
    !(do_push && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem requests, prefetch FIFO, redirect flush
// IFETCH_ALIGN_CHECK_EN adds a sticky misalign_err for unaligned redirect targets.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_count, tag_count;
  logic [31:0]   tag_head, target_aligned;
  fetch_entry_t  head, push_entry;
  logic          issue, push, pop;

  assign target_aligned = {redirect_target[31:2], 2'b00};

  // Credits cover both buffered entries and in-flight requests so a response always has a slot.
  assign imem_req_valid = (state_q == S_RUN) && ((fifo_count + outst_q) < DEPTH_C) &&
                          (outst_q < MAXO_C) && !redirect_valid;
  assign imem_addr      = pc_q;
  assign issue          = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_q == '0);
  assign pop            = instr_valid && instr_ready;
  assign push_entry     = '{instr: imem_rsp_data, pc: tag_head};

  assign instr_valid = (fifo_count != '0);
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q + CW'(issue) - CW'(imem_rsp_valid);
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d   = target_aligned;
      drop_d = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (issue) pc_d = pc_q + 32'(WORD_BYTES);
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    end
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (redirect_valid && outst_d != '0) state_d = S_DRAIN;
      S_DRAIN: if (drop_d == '0) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_data_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // Tags are never flushed: discarded responses still retire their address in order.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (issue),
    .push_data_i (pc_q),
    .pop_i       (imem_rsp_valid),
    .flush_i     (1'b0),
    .head_o      (tag_head),
    .count_o     (tag_count)
  );

  assert property (@(posedge clk) disable iff (reset) tag_count == outst_q);

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else if (redirect_valid && redirect_target[1:0] != 2'b00) misalign_q <= 1'b1;
  end
  assign misalign_err = misalign_q;
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against an instruction-stream model
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          gen;
  } req_t;

  typedef struct {
    int          lat;
    int          min_inflight;
    logic [31:0] target;
    logic [31:0] exp_first_pc;
  } redir_vec_t;

  int          errors = 0;
  int          checks = 0;
  req_t        mq[$];
  int          cyc, last_due, lat, cur_gen, tb_outst, held, n_acc;
  logic        req_rand, wrap_seen;
  logic [31:0] exp_pc, exp_issue, last_pc;
  logic        prev_valid, prev_ready, prev_redir;
  logic [31:0] prev_pc, prev_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (2) @(negedge clk);
    mq.delete();
    cyc = 0; last_due = 0; cur_gen = 0; tb_outst = 0; held = 0; n_acc = 0;
    exp_pc = RESET_PC; exp_issue = RESET_PC; last_pc = '0; wrap_seen = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0; prev_pc = '0; prev_data = '0;
    reset = 1'b0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("rst_misalign", 32'(misalign_err), 0);
`endif
  endtask

  // One clock: memory model, stimulus, then the stream model sampled between edges.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic rsp_new, accepted;
    req_t r;
    @(negedge clk);
    cyc++;
    rsp_new = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(r.addr);
      tb_outst--;
      rsp_new = (r.gen == cur_gen);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready  = req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    instr_ready     = rdy;
    redirect_valid  = redir;
    redirect_target = tgt;
    #1;
    if (redir) chk("no_req_on_redirect", 32'(imem_req_valid), 0);
    if (prev_valid && !prev_ready && !prev_redir) begin
      chk("hold_valid", 32'(instr_valid), 1);
      chk("hold_pc", instr_pc, prev_pc);
      chk("hold_data", instr_data, prev_data);
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("issue_addr", imem_addr, exp_issue);
      tb_outst++;
      chk("outst_le_max", 32'(tb_outst <= MAX_OUTST), 1);
      r.addr = imem_addr;
      r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      r.gen  = cur_gen;
      last_due = r.due;
      mq.push_back(r);
      exp_issue += 32'd4;
    end
    accepted = instr_valid && instr_ready && !redir;
    if (accepted) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_data", instr_data, mem_word(exp_pc));
      if (instr_pc == 32'h0 && last_pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
      last_pc = instr_pc;
      exp_pc += 32'd4;
      n_acc++;
    end
    if (redir) begin
      exp_pc    = {tgt[31:2], 2'b00};
      exp_issue = {tgt[31:2], 2'b00};
      held      = 0;
      cur_gen++;
    end else begin
      held = held + int'(rsp_new) - int'(accepted);
    end
    prev_valid = instr_valid; prev_ready = instr_ready; prev_redir = redir;
    prev_pc = instr_pc; prev_data = instr_data;
  endtask

  task automatic wait_first_accept(input string nm, input logic [31:0] exp_first);
    int n0;
    n0 = n_acc;
    for (int i = 0; i < 80 && n_acc == n0; i++) step(1'b1, 1'b0, '0);
    if (n_acc == n0) chk({nm, "_timeout"}, 32'(n_acc - n0), 1);
    else chk(nm, last_pc, exp_first);
  endtask

  initial begin
    redir_vec_t vecs[6];
    int n0;
    vecs[0] = '{3, 2, 32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{1, 1, 32'h0000_2000, 32'h0000_2000};
    vecs[2] = '{2, 1, 32'h0000_0040, 32'h0000_0040};
    vecs[3] = '{3, 2, 32'h0000_0102, 32'h0000_0100};
    vecs[4] = '{1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[5] = '{4, 2, 32'h0000_0007, 32'h0000_0004};
    req_rand = 1'b0;
    lat = 1;

    // Sustained streaming with single-cycle memory.
    do_reset();
    repeat (5) step(1'b1, 1'b0, '0);
    n0 = n_acc;
    repeat (20) step(1'b1, 1'b0, '0);
    chk("sustained_rate", 32'(n_acc - n0), 20);

    // Decode stall: buffer fills, requests stop, then drains in order.
    repeat (10) step(1'b0, 1'b0, '0);
    chk("stall_held", 32'(held), DEPTH);
    chk("stall_req_idle", 32'(imem_req_valid), 0);
    chk("stall_outst", 32'(tb_outst), 0);
    n0 = n_acc;
    repeat (DEPTH) step(1'b1, 1'b0, '0);
    chk("stall_drain", 32'(n_acc - n0), DEPTH);

    // Redirect table: latency, in-flight count before redirect, target, first instr expected.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      lat = vecs[v].lat;
      repeat (6) step(1'($urandom_range(0, 1)), 1'b0, '0);
      for (int i = 0; i < 30 && tb_outst < vecs[v].min_inflight; i++) step(1'b1, 1'b0, '0);
      chk("redir_inflight", 32'(tb_outst >= vecs[v].min_inflight), 1);
      step(1'b1, 1'b1, vecs[v].target);
      wait_first_accept("redir_first_pc", vecs[v].exp_first_pc);
      repeat (6) step(1'b1, 1'b0, '0);
    end

    // Full buffer with simultaneous pop and redirect: the pop must not count.
    do_reset();
    lat = 2;
    repeat (15) step(1'b0, 1'b0, '0);
    chk("full_held", 32'(held), DEPTH);
    step(1'b1, 1'b1, 32'h0000_0400);
    wait_first_accept("flush_pop_first_pc", 32'h0000_0400);

    // Address wrap at the top of memory.
    do_reset();
    lat = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) step(1'b1, 1'b0, '0);
    chk("pc_wrap", 32'(wrap_seen), 1);

`ifdef IFETCH_ALIGN_CHECK_EN
    do_reset();
    step(1'b1, 1'b1, 32'h0000_0102);
    chk("misalign_set", 32'(misalign_err), 1);
    wait_first_accept("misalign_fetch", 32'h0000_0100);
    chk("misalign_sticky", 32'(misalign_err), 1);
`endif

    // Randomized traffic with variable latency, backpressure, redirects and a mid-run reset.
    do_reset();
    req_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      lat = $urandom_range(1, 4);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), $urandom);
    end
    chk("random_progress", 32'(n_acc > 100), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
